gpio_write_arbiter: RTL and testbench
=====================================

# gpio_write_arbiter

Two-requester write arbiter and sequencer for the memory-mapped GPIO output register. It accepts write requests from the CPU store path (requester 0) and the debug/test port (requester 1), arbitrates round-robin, and issues one single-cycle write strobe with address and data onto the GPIO write bus. It returns a per-requester acknowledge, flags address misses, and keeps per-requester write counters.

## Interface
- GPIO_ADDR, 32'hABCD, only address for which a write strobe is issued
- DW, 32, address/data width
- CNTW, 16, width of each saturating write counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  write request; held high until the matching ack pulse
- addr0, addr1  in  DW  request address; stable while req high
- wdata0, wdata1  in  DW  request data; stable while req high
- ack0, ack1  out  1  one-cycle completion pulse, registered
- err0, err1  out  1  address-miss flag, valid only with the matching ack
- bus_memwrite  out  1  write strobe to GPIO register, registered
- bus_addr  out  DW  write address, registered
- bus_wdata  out  DW  write data, registered
- wcnt0, wcnt1  out  CNTW  successful (hit) write count per requester, saturating

## Operation
- Priority pointer `last`: 0 after reset. Toggles to the served requester after each service.
- States: IDLE, ISSUE, ACK.
- IDLE: no request -> stay in IDLE. One request -> grant it. Both requests -> grant the requester that was not served last. After reset, the first tie goes to req1. On grant: latch addr/wdata into bus_addr/bus_wdata, set `hit` = (addr == GPIO_ADDR), go to ISSUE.
- ISSUE: bus_memwrite = hit for exactly this cycle. bus_addr and bus_wdata are held. Go to ACK.
- ACK: pulse ackN = 1 for the granted requester. errN = !hit. If hit, wcntN += 1, saturating at 2^CNTW-1. last = N. Go to IDLE.
- A miss issues no strobe and does not count, but it still acks and updates the priority pointer.
- bus_addr/bus_wdata hold their last values outside ISSUE. bus_memwrite is 0 in every state except ISSUE.
- Requests that change addr/wdata while waiting are not protected. Values are captured at the grant edge.
- A req that drops before grant is simply not served.

## Timing
- Reset (asynchronous assertion, any state): state = IDLE, last = 0, and ack0/ack1/err0/err1/bus_memwrite = 0. bus_addr = 0, bus_wdata = 0, wcnt0 = wcnt1 = 0. An in-flight write is aborted with no ack.
- Release is synchronous to the next clk edge. The first grant can occur at the first edge with rst_n high.
- Latency: req high at edge E0 (IDLE) -> bus_memwrite high in cycle E0..E1 -> ackN high in cycle E1..E2 -> IDLE at E2.
- The requester drops req in the cycle after it samples ack. The IDLE sample at E3 sees req low, so there is no double service.
- Sustained throughput with back-to-back requests: one write per 3 cycles.
- Simultaneous requests with alternating priority interleave 0,1,0,1… with no starvation.
- ack and err never assert outside ACK. Both acks are never high in the same cycle.
- The downstream GPIO register samples bus_* at the edge ending the ISSUE cycle.

## Test plan
- Reset values: hold rst_n=0, then release. All outputs are 0. Assert rst_n=0 mid-ISSUE: bus_memwrite drops immediately and no ack follows.
- Single hit: req0 with addr0=32'hABCD, wdata0=32'h1234_5678. Next cycle: bus_memwrite=1, bus_addr=32'hABCD, bus_wdata=32'h1234_5678. Following cycle: ack0=1, err0=0, wcnt0=1.
- Miss: req1 with addr1=32'h0000_0010. No bus_memwrite pulse, ack1=1 with err1=1, wcnt1 stays 0.
- Contention: req0 and req1 held high continuously after reset. Service order is 1,0,1,0. Acks land every 3 cycles, and wcnt0 and wcnt1 each reach 2 after 4 services.
- Saturation: with CNTW=2, issue 5 hit writes from req0. wcnt0 = 3 after the 3rd write and stays 3.
- Late drop: raise req1 for one cycle while a req0 write is in ISSUE, then drop it. req1 is never acked and only the req0 write appears on the bus.

Source files
------------

// File: rtl/gpio_write_arbiter_if.sv
// Request/acknowledge and GPIO write-bus bundle between the two requesters and the arbiter.
// master = requester side (drives req/addr/wdata), slave = arbiter side.
interface gpio_write_arbiter_if #(
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    logic            req0;
    logic            req1;
    logic [DW-1:0]   addr0;
    logic [DW-1:0]   addr1;
    logic [DW-1:0]   wdata0;
    logic [DW-1:0]   wdata1;
    logic            ack0;
    logic            ack1;
    logic            err0;
    logic            err1;
    logic            bus_memwrite;
    logic [DW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [CNTW-1:0] wcnt0;
    logic [CNTW-1:0] wcnt1;

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1,
        input  bus_memwrite, bus_addr, bus_wdata,
        input  wcnt0, wcnt1
    );

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1,
        output bus_memwrite, bus_addr, bus_wdata,
        output wcnt0, wcnt1
    );
endinterface

// File: rtl/gpio_write_arbiter.sv
// Round-robin two-requester write sequencer for the GPIO output register: IDLE -> ISSUE -> ACK.
// Latency: grant edge -> strobe for one cycle -> ack for one cycle; one write per 3 cycles.
// Backpressure: requesters hold req until ack; a req dropped before grant is never served.
module gpio_write_arbiter #(
    parameter int            DW        = 32,
    parameter int            CNTW      = 16,
    parameter logic [DW-1:0] GPIO_ADDR = DW'(32'hABCD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gpio_write_arbiter_if.slave  wr_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state_q;
    logic            last_q;
    logic            gnt_q;
    logic            hit_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            err0_q;
    logic            err1_q;
    logic            bus_memwrite_q;
    logic [DW-1:0]   bus_addr_q;
    logic [DW-1:0]   bus_wdata_q;
    logic [CNTW-1:0] wcnt0_q;
    logic [CNTW-1:0] wcnt1_q;

    logic            any_req;
    logic            gnt_d;
    logic [DW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_hit;
    logic [CNTW-1:0] wcnt0_d;
    logic [CNTW-1:0] wcnt1_d;

    // On a tie the requester not served last wins; last resets to 0 so the first tie goes to req1.
    always_comb begin
        any_req = wr_if.req0 | wr_if.req1;
        gnt_d   = wr_if.req1;
        if (wr_if.req0 && wr_if.req1) begin
            gnt_d = ~last_q;
        end
        sel_addr  = gnt_d ? wr_if.addr1  : wr_if.addr0;
        sel_wdata = gnt_d ? wr_if.wdata1 : wr_if.wdata0;
        sel_hit   = (sel_addr == GPIO_ADDR);
        wcnt0_d   = (wcnt0_q == {CNTW{1'b1}}) ? wcnt0_q : wcnt0_q + CNTW'(1);
        wcnt1_d   = (wcnt1_q == {CNTW{1'b1}}) ? wcnt1_q : wcnt1_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_q         <= 1'b0;
            gnt_q          <= 1'b0;
            hit_q          <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            bus_memwrite_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            wcnt0_q        <= '0;
            wcnt1_q        <= '0;
        end else begin
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            bus_memwrite_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q          <= gnt_d;
                        hit_q          <= sel_hit;
                        bus_addr_q     <= sel_addr;
                        bus_wdata_q    <= sel_wdata;
                        bus_memwrite_q <= sel_hit;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ack, error and counter update all become visible together in the ACK cycle.
                    if (gnt_q) begin
                        ack1_q <= 1'b1;
                        err1_q <= ~hit_q;
                        if (hit_q) begin
                            wcnt1_q <= wcnt1_d;
                        end
                    end else begin
                        ack0_q <= 1'b1;
                        err0_q <= ~hit_q;
                        if (hit_q) begin
                            wcnt0_q <= wcnt0_d;
                        end
                    end
                    last_q  <= gnt_q;
                    state_q <= ACK;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_if.ack0         = ack0_q;
    assign wr_if.ack1         = ack1_q;
    assign wr_if.err0         = err0_q;
    assign wr_if.err1         = err1_q;
    assign wr_if.bus_memwrite = bus_memwrite_q;
    assign wr_if.bus_addr     = bus_addr_q;
    assign wr_if.bus_wdata    = bus_wdata_q;
    assign wr_if.wcnt0        = wcnt0_q;
    assign wr_if.wcnt1        = wcnt1_q;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Scoreboard bench: a 16-bit-counter instance and a 2-bit-counter instance see identical requests.
module tb_gpio_write_arbiter;

    localparam logic [31:0] GA = 32'hABCD;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    logic clk;
    logic rst_n;

    gpio_write_arbiter_if #(.DW(32), .CNTW(16)) ifa ();
    gpio_write_arbiter_if #(.DW(32), .CNTW(2))  ifb ();

    gpio_write_arbiter #(.DW(32), .CNTW(16)) dut_a (.clk(clk), .rst_n(rst_n), .wr_if(ifa));
    gpio_write_arbiter #(.DW(32), .CNTW(2))  dut_b (.clk(clk), .rst_n(rst_n), .wr_if(ifb));

    assign ifb.req0   = ifa.req0;
    assign ifb.req1   = ifa.req1;
    assign ifb.addr0  = ifa.addr0;
    assign ifb.addr1  = ifa.addr1;
    assign ifb.wdata0 = ifa.wdata0;
    assign ifb.wdata1 = ifa.wdata1;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   cnt0 = 0;
    int   cnt1 = 0;
    bit   strobe_seen = 0;
    int   n_ack0 = 0;
    int   n_ack1 = 0;
    int   n_strobe = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat2(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic reset_model();
        sb.delete();
        cnt0 = 0;
        cnt1 = 0;
        strobe_seen = 0;
    endtask

    // Monitor: strobes are checked against the queue head, acks pop it.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("protocol", {ifa.ack0 & ifa.ack1, ifa.err0 & ~ifa.ack0, ifa.err1 & ~ifa.ack1,
                             ifa.bus_memwrite ^ ifb.bus_memwrite}, 4'b0);
            if (ifa.bus_memwrite) begin
                n_strobe++;
                chk("strobe_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    chk("strobe_addr", ifa.bus_addr, sb[0].addr);
                    chk("strobe_data", ifa.bus_wdata, sb[0].data);
                    strobe_seen = 1;
                end
            end
            if (ifa.ack0 | ifa.ack1) begin
                if (ifa.ack0) n_ack0++;
                if (ifa.ack1) n_ack1++;
                chk("ack_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("ack_id", ifa.ack1, mon_e.id == 1);
                    chk("err", ifa.ack1 ? ifa.err1 : ifa.err0, !mon_e.hit);
                    chk("strobe_iff_hit", strobe_seen, mon_e.hit);
                    strobe_seen = 0;
                    if (mon_e.hit) begin
                        if (mon_e.id == 1) cnt1++; else cnt0++;
                    end
                    chk("wcnt0_a", ifa.wcnt0, cnt0 & 16'hFFFF);
                    chk("wcnt1_a", ifa.wcnt1, cnt1 & 16'hFFFF);
                    chk("wcnt0_b", ifb.wcnt0, sat2(cnt0));
                    chk("wcnt1_b", ifb.wcnt1, sat2(cnt1));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after dropping req.
    task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   got;
        int   n;
        e.id = id; e.addr = a; e.data = d; e.hit = (a == GA);
        sb.push_back(e);
        if (id == 0) begin
            ifa.req0 = 1'b1; ifa.addr0 = a; ifa.wdata0 = d;
        end else begin
            ifa.req1 = 1'b1; ifa.addr1 = a; ifa.wdata1 = d;
        end
        got = 0;
        n   = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = (id == 1) ? ifa.ack1 : ifa.ack0;
            n   = i;
        end
        chk("ack_timeout", got, 1);
        chk("ack_latency", n, 2);
        @(posedge clk);
        #1;
        if (id == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a0, a1, s0, k;
        int ack_at[4];
        exp_t e;

        rst_n = 1'b0;
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {ifa.ack0, ifa.ack1, ifa.err0, ifa.err1, ifa.bus_memwrite}, 5'b0);
        chk("rst_addr", ifa.bus_addr, 0);
        chk("rst_wdata", ifa.bus_wdata, 0);
        chk("rst_wcnt", {ifa.wcnt0, ifa.wcnt1}, 0);
        chk("rst_b", {ifb.ack0, ifb.ack1, ifb.bus_memwrite, ifb.wcnt0, ifb.wcnt1}, 0);
        rst_n = 1'b1;

        // Single hit from requester 0, then the bus holds its values in IDLE.
        do_req(0, GA, 32'h1234_5678);
        chk("hold_addr", ifa.bus_addr, GA);
        chk("hold_wdata", ifa.bus_wdata, 32'h1234_5678);
        chk("idle_no_strobe", ifa.bus_memwrite, 0);

        // Miss from requester 1: acked with err, no strobe, no count.
        do_req(1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("miss_addr_latched", ifa.bus_addr, 32'h0000_0010);
        chk("miss_wcnt1", ifa.wcnt1, 0);

        // Reset asserted mid-ISSUE aborts the write with no ack.
        e.id = 0; e.addr = GA; e.data = 32'h5555_AAAA; e.hit = 1;
        sb.push_back(e);
        ifa.req0 = 1'b1; ifa.addr0 = GA; ifa.wdata0 = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        chk("mid_issue_strobe", ifa.bus_memwrite, 1);
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("abort_strobe_drop", ifa.bus_memwrite, 0);
        chk("abort_addr_clr", ifa.bus_addr, 0);
        chk("abort_wcnt0_clr", ifa.wcnt0, 0);
        ifa.req0 = 1'b0;
        a0 = n_ack0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_ack", n_ack0, a0);

        // Contention from reset: service order 1,0,1,0 every 3 cycles.
        rst_n = 1'b0;
        reset_model();
        ifa.req0 = 1'b1; ifa.addr0 = GA; ifa.wdata0 = 32'hC0C0_0000;
        ifa.req1 = 1'b1; ifa.addr1 = GA; ifa.wdata1 = 32'hC1C1_1111;
        for (int j = 0; j < 4; j++) begin
            e.id   = (j % 2 == 0) ? 1 : 0;
            e.addr = GA;
            e.data = (e.id == 1) ? 32'hC1C1_1111 : 32'hC0C0_0000;
            e.hit  = 1;
            sb.push_back(e);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk);
            if (ifa.ack0 | ifa.ack1) begin
                ack_at[k] = i;
                k++;
            end
        end
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        chk("cont_ack_count", k, 4);
        if (k == 4) begin
            for (int j = 1; j < 4; j++) chk("cont_spacing", ack_at[j] - ack_at[j-1], 3);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("cont_drained", sb.size(), 0);
        chk("cont_wcnt0", ifa.wcnt0, 2);
        chk("cont_wcnt1", ifa.wcnt1, 2);

        // Late drop: req1 pulses for one cycle during req0's ISSUE and is never served.
        s0 = n_strobe;
        a1 = n_ack1;
        fork
            do_req(0, GA, 32'h0BAD_F00D);
            begin
                @(posedge clk);
                #1;
                ifa.req1 = 1'b1; ifa.addr1 = GA; ifa.wdata1 = 32'h1111_2222;
                @(posedge clk);
                #1;
                ifa.req1 = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("late_drop_no_ack1", n_ack1, a1);
        chk("late_drop_one_strobe", n_strobe - s0, 1);

        // Saturation: the 2-bit counter sticks at 3 from the third hit on.
        rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_req(0, GA, 32'h5A00_0000 + i);
            if (i >= 2) chk("sat_b_wcnt0", ifb.wcnt0, 3);
        end
        chk("sat_a_wcnt0", ifa.wcnt0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
